// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences a single-ported, fixed-latency unified memory
// shared by the fetch stage (IF) and the memory stage (DM). DM wins by
// default. IF wins when DM is idle, or when IF has been passed over
// STARVE_MAX times in a row. Each access takes MEM_LAT+2 cycles:
// grant, MEM_LAT-1 wait cycles, capture, then one done/dead cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,

  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,

  input  logic              halt,

  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_LAST   = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_owner_dm;
  logic              r_acc_wr;
  logic [3:0]        r_lat;
  logic [SW-1:0]     r_starve;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_done;
  logic              r_dm_done;

  logic w_idle;
  logic w_if_elig;
  logic w_starved;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_grant;
  logic w_lat_last;

  // Arbitration terms; a grant can only happen in IDLE.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_if_elig  = if_req & ~halt;
    w_starved  = (r_starve == STARVE_LIM);
    w_grant_if = w_idle & w_if_elig & (~dm_req | w_starved);
    w_grant_dm = w_idle & dm_req & ~w_grant_if;
    w_grant    = w_grant_if | w_grant_dm;
    w_lat_last = (r_state == S_BUSY) & (r_lat == LAT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: DONE always returns to IDLE without arbitrating, so a
  // requester sees its done pulse before it can be granted again.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_lat_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access latch: owner, address, write flag and store data are held from
  // the grant until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_dm  <= 1'b0;
      r_acc_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant) begin
      r_owner_dm  <= w_grant_dm;
      r_acc_wr    <= w_grant_dm & dm_wr;
      r_mem_addr  <= w_grant_dm ? dm_addr : if_addr;
      r_mem_wdata <= w_grant_dm ? dm_wdata : '0;
    end
  end

  // One-cycle strobe following the grant edge; mem_wr only rides with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en <= 1'b0;
      r_mem_wr <= 1'b0;
    end else begin
      r_mem_en <= w_grant;
      r_mem_wr <= w_grant_dm & dm_wr;
    end
  end

  // Latency counter: zero at grant, counts BUSY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat <= '0;
    end else if (w_grant) begin
      r_lat <= '0;
    end else if (r_state == S_BUSY) begin
      r_lat <= r_lat + 4'd1;
    end
  end

  // Read capture into the owner's data register; writes leave it intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (w_lat_last && !r_acc_wr) begin
      if (r_owner_dm) begin
        r_dm_rdata <= mem_rdata;
      end else begin
        r_if_rdata <= mem_rdata;
      end
    end
  end

  // Completion pulses, high only in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
    end else begin
      r_if_done <= w_lat_last & ~r_owner_dm;
      r_dm_done <= w_lat_last & r_owner_dm;
    end
  end

  // Starvation counter: counts DM grants that passed over an eligible IF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_grant_if) begin
      r_starve <= '0;
    end else if (w_grant_dm) begin
      if (w_if_elig) begin
        if (!w_starved) r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end

  // Output drive.
  always_comb begin
    mem_en    = r_mem_en;
    mem_wr    = r_mem_wr;
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    if_rdata  = r_if_rdata;
    dm_rdata  = r_dm_rdata;
    if_done   = r_if_done;
    dm_done   = r_dm_done;
    if_stall  = if_req & ~r_if_done;
    dm_stall  = dm_req & ~r_dm_done;
  end

endmodule
